// File: rtl/gates_checker.sv
// Built-in self-test engine for the two-input gates block: sweeps {b,a} through 00..11 PASSES times,
// holds each vector SETTLE cycles, then checks all eight gate outputs against the truth table.
module gates_checker #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       ya,
    input  logic       yna,
    input  logic       yo,
    input  logic       yno,
    input  logic       yx,
    input  logic       yxn,
    input  logic       ynota,
    input  logic       ynotb,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_mask,
    output logic [7:0] err_count,
    output logic [1:0] first_fail,
    output logic       first_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic [3:0] pidx_q;
    logic       busy_q, done_q, pass_q, first_valid_q;
    logic [7:0] err_mask_q, err_count_q;
    logic [1:0] first_fail_q;

    logic [7:0] actual, expected, mism;
    logic [3:0] mism_pop;
    logic [8:0] cnt_sum;
    logic [7:0] err_mask_d, err_count_d;
    logic       last_vec;

    always_comb begin
        actual   = {ynotb, ynota, yxn, yx, yno, yo, yna, ya};
        expected = {~vec_q[1], ~vec_q[0],
                    ~(vec_q[0] ^ vec_q[1]), vec_q[0] ^ vec_q[1],
                    ~(vec_q[0] | vec_q[1]), vec_q[0] | vec_q[1],
                    ~(vec_q[0] & vec_q[1]), vec_q[0] & vec_q[1]};
        mism     = actual ^ expected;
        mism_pop = '0;
        for (int i = 0; i < 8; i++) begin
            mism_pop = mism_pop + {3'b000, mism[i]};
        end
        cnt_sum     = {1'b0, err_count_q} + {5'b00000, mism_pop};
        // Sum never exceeds 255+8, so bit 8 alone marks overflow.
        err_count_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        err_mask_d  = err_mask_q | mism;
        last_vec    = (vec_q == 2'd3) && (pidx_q == 4'(PASSES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            vec_q         <= 2'd0;
            cnt_q         <= 4'd0;
            pidx_q        <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_mask_q    <= 8'd0;
            err_count_q   <= 8'd0;
            first_fail_q  <= 2'd0;
            first_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        vec_q         <= 2'd0;
                        pidx_q        <= 4'd0;
                        cnt_q         <= 4'(SETTLE);
                        busy_q        <= 1'b1;
                        pass_q        <= 1'b0;
                        err_mask_q    <= 8'd0;
                        err_count_q   <= 8'd0;
                        first_fail_q  <= 2'd0;
                        first_valid_q <= 1'b0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) state_q <= SAMPLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                SAMPLE: begin
                    err_mask_q  <= err_mask_d;
                    err_count_q <= err_count_d;
                    if (mism != 8'd0 && !first_valid_q) begin
                        first_fail_q  <= vec_q;
                        first_valid_q <= 1'b1;
                    end
                    if (!last_vec) begin
                        vec_q   <= vec_q + 2'd1;
                        if (vec_q == 2'd3) pidx_q <= pidx_q + 4'd1;
                        cnt_q   <= 4'(SETTLE);
                        state_q <= WAIT;
                    end else begin
                        pass_q  <= (err_mask_d == 8'd0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a           = vec_q[0];
    assign b           = vec_q[1];
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_mask    = err_mask_q;
    assign err_count   = err_count_q;
    assign first_fail  = first_fail_q;
    assign first_valid = first_valid_q;

endmodule

// File: tb/tb_gates_checker.sv
// Bench for gates_checker: four instances with different SETTLE/PASSES, each fed by a modelled gates DUT
// whose fault mode is selectable; spec scenarios come from a table, random faults from a reference model.
module tb_gates_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] st, aa, bb, busy, done, pass, fv;
    logic [7:0] em [4];
    logic [7:0] ec [4];
    logic [1:0] ff [4];
    logic [7:0] y  [4];
    int         mode [4];
    logic [31:0] rmk [4];

    int S [4] = '{1, 1, 1, 3};
    int P [4] = '{1, 3, 15, 2};

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    // Truth table packed as {ynotb,ynota,yxn,yx,yno,yo,yna,ya} for vector {b,a}.
    function automatic logic [7:0] ideal(input logic [1:0] v);
        case (v)
            2'b00:   ideal = 8'hEA;
            2'b01:   ideal = 8'h96;
            2'b10:   ideal = 8'h56;
            default: ideal = 8'h25;
        endcase
    endfunction

    // Modelled gates block with an optional fault: 1 yx stuck 0, 2 ynota/ynotb swapped,
    // 3 yno stuck 1, 4 all inverted, 5 per-vector random corruption taken from rm.
    function automatic logic [7:0] resp(input logic [1:0] v, input int md, input logic [31:0] rm);
        logic [7:0] r;
        r = ideal(v);
        case (md)
            1:       r = r & ~8'h10;
            2:       r = {r[6], r[7], r[5:0]};
            3:       r = r | 8'h08;
            4:       r = ~r;
            5:       r = r ^ rm[8*v +: 8];
            default: r = r;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign y[g] = resp({bb[g], aa[g]}, mode[g], rmk[g]);
        gates_checker #(
            .SETTLE(g == 3 ? 3 : 1),
            .PASSES(g == 0 ? 1 : (g == 1 ? 3 : (g == 2 ? 15 : 2)))
        ) u_dut (
            .clk(clk), .rst(rst), .start(st[g]), .a(aa[g]), .b(bb[g]),
            .ya(y[g][0]), .yna(y[g][1]), .yo(y[g][2]), .yno(y[g][3]),
            .yx(y[g][4]), .yxn(y[g][5]), .ynota(y[g][6]), .ynotb(y[g][7]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .err_mask(em[g]), .err_count(ec[g]), .first_fail(ff[g]), .first_valid(fv[g])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference results from the fault model: per-vector mismatch, OR-ed, counted over all passes.
    task automatic model(input int i, output logic [7:0] m, output int c,
                         output logic [1:0] f, output logic v, output logic p);
        int raw;
        logic [7:0] d;
        raw = 0; m = 8'd0; f = 2'd0; v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = resp(2'(k), mode[i], rmk[i]) ^ ideal(2'(k));
            m = m | d;
            raw += $countones(d);
            if (d != 8'd0 && !v) begin
                v = 1'b1;
                f = 2'(k);
            end
        end
        c = raw * P[i];
        if (c > 255) c = 255;
        p = (m == 8'd0);
    endtask

    // One full run on instance i, checking the vector timeline, done/busy timing and final results.
    task automatic run(input int i, input bit poke, input string nm, input logic [7:0] xm,
                       input int xc, input logic [1:0] xf, input logic xv, input logic xp);
        int n;
        n = 4 * P[i] * (S[i] + 1);
        @(negedge clk); st[i] = 1'b1;
        @(posedge clk); #1; st[i] = 1'b0;
        for (int t = 0; t <= n + 1; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            if (poke && t == 2) st[i] = 1'b1;
            if (poke && t == 3) st[i] = 1'b0;
            if (t < n) begin
                chk({nm, " vec"}, int'({bb[i], aa[i]}), (t / (S[i] + 1)) % 4);
                chk({nm, " busy"}, int'(busy[i]), 1);
                chk({nm, " done early"}, int'(done[i]), 0);
            end else if (t == n) begin
                chk({nm, " done"}, int'(done[i]), 1);
                chk({nm, " busy end"}, int'(busy[i]), 0);
                chk({nm, " last vec"}, int'({bb[i], aa[i]}), 3);
                chk({nm, " pass"}, int'(pass[i]), int'(xp));
                chk({nm, " err_mask"}, int'(em[i]), int'(xm));
                chk({nm, " err_count"}, int'(ec[i]), xc);
                chk({nm, " first_valid"}, int'(fv[i]), int'(xv));
                chk({nm, " first_fail"}, int'(ff[i]), int'(xf));
            end else begin
                chk({nm, " done fall"}, int'(done[i]), 0);
                chk({nm, " idle busy"}, int'(busy[i]), 0);
                chk({nm, " held mask"}, int'(em[i]), int'(xm));
                chk({nm, " held pass"}, int'(pass[i]), int'(xp));
            end
        end
    endtask

    typedef struct {
        int         inst;
        int         md;
        logic [7:0] mask;
        int         cnt;
        logic [1:0] ffail;
        logic       fval;
        logic       ok;
    } vec_t;

    initial begin
        vec_t tbl [8];
        logic [7:0] xm;
        int xc;
        logic [1:0] xf;
        logic xv, xp;

        tbl[0] = '{0, 0, 8'h00, 0,   2'b00, 1'b0, 1'b1};
        tbl[1] = '{0, 1, 8'h10, 2,   2'b01, 1'b1, 1'b0};
        tbl[2] = '{0, 2, 8'hC0, 4,   2'b01, 1'b1, 1'b0};
        tbl[3] = '{1, 3, 8'h08, 9,   2'b01, 1'b1, 1'b0};
        tbl[4] = '{2, 4, 8'hFF, 255, 2'b00, 1'b1, 1'b0};
        tbl[5] = '{0, 4, 8'hFF, 32,  2'b00, 1'b1, 1'b0};
        tbl[6] = '{1, 0, 8'h00, 0,   2'b00, 1'b0, 1'b1};
        tbl[7] = '{3, 3, 8'h08, 6,   2'b01, 1'b1, 1'b0};

        rst = 1'b1;
        st  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            mode[i] = 0;
            rmk[i]  = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset ab", int'({bb[i], aa[i]}), 0);
            chk("reset busy", int'(busy[i]), 0);
            chk("reset done", int'(done[i]), 0);
            chk("reset pass", int'(pass[i]), 0);
            chk("reset mask", int'(em[i]), 0);
            chk("reset count", int'(ec[i]), 0);
            chk("reset first", int'({fv[i], ff[i]}), 0);
        end
        @(negedge clk); rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            mode[tbl[r].inst] = tbl[r].md;
            run(tbl[r].inst, 1'b0, $sformatf("tbl%0d", r), tbl[r].mask, tbl[r].cnt,
                tbl[r].ffail, tbl[r].fval, tbl[r].ok);
        end

        // Random per-vector corruption; each vector left clean about half the time.
        for (int r = 0; r < 14; r++) begin
            int i;
            i = (r < 11) ? 3 : 2;
            mode[i] = 5;
            for (int k = 0; k < 4; k++)
                rmk[i][8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            model(i, xm, xc, xf, xv, xp);
            run(i, r[0], $sformatf("rnd%0d", r), xm, xc, xf, xv, xp);
        end

        // Mid-run reset during WAIT of vector 10, with an ignored start while busy.
        mode[0] = 4;
        @(negedge clk); st[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk); #1;
            if (t == 1) st[0] = 1'b1;
            if (t == 2) st[0] = 1'b0;
        end
        chk("pre-rst vec", int'({bb[0], aa[0]}), 2);
        chk("pre-rst mask", int'(em[0]), 8'hFF);
        chk("pre-rst count", int'(ec[0]), 16);
        chk("pre-rst busy", int'(busy[0]), 1);
        #3 rst = 1'b1;
        #1;
        chk("rst ab", int'({bb[0], aa[0]}), 0);
        chk("rst busy", int'(busy[0]), 0);
        chk("rst done", int'(done[0]), 0);
        chk("rst pass", int'(pass[0]), 0);
        chk("rst mask", int'(em[0]), 0);
        chk("rst count", int'(ec[0]), 0);
        chk("rst first", int'({fv[0], ff[0]}), 0);
        @(negedge clk); rst = 1'b0;
        mode[0] = 0;
        run(0, 1'b1, "rerun", 8'h00, 0, 2'b00, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
